// File: rtl/tinyalu_cmd_driver.sv
// Initiator-side driver for a combinational tinyalu: accepts commands, holds operands
// for SETTLE_CYCLES cycles, captures the 16-bit result and queues it for the consumer.
module tinyalu_cmd_driver #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RSP_DEPTH     = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             alu_reset,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [15:0]      alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [2:0]       rsp_op,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int FC_W  = PTR_W + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SET_W-1:0]   settle_r;
    logic               alu_reset_r;
    logic [2:0]         alu_op_r;
    logic [7:0]         alu_a_r;
    logic [7:0]         alu_b_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cmd_count_r;

    logic [15:0]        data_mem_r [RSP_DEPTH];
    logic [2:0]         op_mem_r   [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [FC_W-1:0]    fifo_cnt_r;
    logic [FC_W-1:0]    fifo_cnt_nxt_s;
    logic               rsp_valid_r;

    logic               accept_s;
    logic               push_s;
    logic               pop_s;

    assign accept_s = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
    assign push_s   = (state_r == ST_DRIVE) && (settle_r == {SET_W{1'b0}});
    assign pop_s    = rsp_valid_r & rsp_ready;

    // Next FSM state, shared by the FSM and the look-ahead for the registered cmd_ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (push_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRIVE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        if (push_s && !pop_s) begin
            fifo_cnt_nxt_s = fifo_cnt_r + FC_W'(1);
        end else if (!push_s && pop_s) begin
            fifo_cnt_nxt_s = fifo_cnt_r - FC_W'(1);
        end else begin
            fifo_cnt_nxt_s = fifo_cnt_r;
        end
    end

    // Command FSM: operand registers, ALU reset pin, settle timer and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            settle_r    <= {SET_W{1'b0}};
            alu_reset_r <= 1'b1;
            alu_op_r    <= 3'd0;
            alu_a_r     <= 8'd0;
            alu_b_r     <= 8'd0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            cmd_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s == ST_DRIVE);
            // Registered version of "IDLE and a FIFO slot is free" for the coming cycle.
            cmd_ready_r <= (state_nxt_s == ST_IDLE) && (fifo_cnt_nxt_s < FC_W'(RSP_DEPTH));
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_op_r    <= cmd_op;
                        alu_a_r     <= cmd_a;
                        alu_b_r     <= cmd_b;
                        alu_reset_r <= 1'b0;
                        settle_r    <= SET_W'(SETTLE_CYCLES - 1);
                    end else begin
                        alu_reset_r <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (push_s) begin
                        alu_reset_r <= 1'b1;
                        cmd_count_r <= cmd_count_r + CNT_W'(1);
                    end else begin
                        settle_r    <= settle_r - SET_W'(1);
                    end
                end
                default: begin
                    alu_reset_r <= 1'b1;
                end
            endcase
        end
    end

    // Response FIFO; pointers wrap naturally because RSP_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {FC_W{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= alu_out;
                op_mem_r[wr_ptr_r]   <= alu_op_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            rsp_valid_r <= (fifo_cnt_nxt_s != {FC_W{1'b0}});
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign alu_reset = alu_reset_r;
    assign alu_op    = alu_op_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = data_mem_r[rd_ptr_r];
    assign rsp_op    = op_mem_r[rd_ptr_r];
    assign busy      = busy_r;
    assign cmd_count = cmd_count_r;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Scoreboard bench for tinyalu_cmd_driver: a behavioural tinyalu closes the loop,
// expected responses are queued at command accept and checked by a separate monitor.
module tb_tinyalu_cmd_driver;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_reset;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        busy;
    logic [7:0]  cmd_count;

    // second instance with a narrow counter to observe wrap
    logic        cmd_ready4;
    logic        alu_reset4;
    logic [2:0]  alu_op4;
    logic [7:0]  alu_a4;
    logic [7:0]  alu_b4;
    logic [15:0] alu_out4;
    logic        rsp_valid4;
    logic [15:0] rsp_data4;
    logic [2:0]  rsp_op4;
    logic        busy4;
    logic [3:0]  cmd_count4;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic        rand_rdy = 1'b0;
    logic [18:0] exp_q[$];

    tinyalu_cmd_driver #(.SETTLE_CYCLES(2), .RSP_DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_reset(alu_reset),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .busy(busy), .cmd_count(cmd_count)
    );

    tinyalu_cmd_driver #(.SETTLE_CYCLES(2), .RSP_DEPTH(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_reset(alu_reset4),
        .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_out(alu_out4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
        .rsp_op(rsp_op4), .busy(busy4), .cmd_count(cmd_count4)
    );

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            3'b000:  return wa;
            3'b001:  return wa + wb;
            3'b010:  return wa - wb;
            3'b011:  return wa * wb;
            3'b100:  return wa & wb;
            3'b101:  return wa | wb;
            3'b110:  return wa ^ wb;
            default: return ~wa;
        endcase
    endfunction

    assign alu_out  = alu_reset  ? 16'h0000 : alu_f(alu_op, alu_a, alu_b);
    assign alu_out4 = alu_reset4 ? 16'h0000 : alu_f(alu_op4, alu_a4, alu_b4);

    // directed vectors with hand-computed results
    logic [2:0]  v_op  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [7:0]  v_a   [8] = '{8'h3C, 8'hFF, 8'h05, 8'hFF, 8'hF0, 8'hF0, 8'hAA, 8'h0F};
    logic [7:0]  v_b   [8] = '{8'h11, 8'h01, 8'h07, 8'hFF, 8'h3C, 8'h0F, 8'h55, 8'h99};
    logic [15:0] v_exp [8] = '{16'h003C, 16'h0100, 16'hFFFE, 16'hFE01, 16'h0030, 16'h00FF, 16'h00FF, 16'hFFF0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // monitor: compare the head response whenever it is handed over
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got op=%h data=%h, required no response", rsp_op, rsp_data);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({rsp_op, rsp_data} !== e) begin
                    n_err++;
                    $display("FAIL rsp_data: got op=%h data=%h, required op=%h data=%h",
                             rsp_op, rsp_data, e[18:16], e[15:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // called at a negedge; returns at the negedge following the accept edge
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back({op, exp});
            @(posedge clk);
            #1;
            acc_cyc   = cyc;
            cmd_valid = 1'b0;
            cmd_op    = ~op;
            cmd_a     = ~a;
            cmd_b     = ~b;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int prev;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        rsp_ready = 1'b0;

        // 1: reset state
        do_reset();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_reset", 32'(alu_reset), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 2: single add, timing of alu_reset / rsp_valid
        rsp_ready = 1'b1;
        send(3'b001, 8'hFF, 8'h01, 16'h0100);
        check("t2_alu_reset_e1", 32'(alu_reset), 32'd0);
        check("t2_alu_a", 32'(alu_a), 32'hFF);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_cmd_ready_drive", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("t2_alu_reset_e2", 32'(alu_reset), 32'd0);
        check("t2_rsp_valid_early", 32'(rsp_valid), 32'd0);
        check("t2_alu_b_held", 32'(alu_b), 32'h01);
        @(negedge clk);
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_alu_reset_back", 32'(alu_reset), 32'd1);
        check("t2_cmd_ready_again", 32'(cmd_ready), 32'd1);
        drain();
        check("t2_cmd_count", 32'(cmd_count), 32'd1);

        // 3: fill FIFO with rsp_ready low, 5th command must stall
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'b011, 8'hFF, 8'hFF, 16'hFE01);
        cmd_valid = 1'b1;
        cmd_op    = 3'b011;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        repeat (10) @(negedge clk);
        check("t3_full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("t3_cmd_count", 32'(cmd_count), 32'd4);
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check("t3_cmd_count_after", 32'(cmd_count), 32'd4);

        // 4: mixed ops with random rsp_ready
        do_reset();
        rand_rdy = 1'b1;
        send(3'b010, 8'h05, 8'h07, 16'hFFFE);
        send(3'b111, 8'h0F, 8'h00, 16'hFFF0);
        send(3'b110, 8'hAA, 8'h55, 16'h00FF);
        rand_rdy = 1'b0;
        #3;
        rsp_ready = 1'b1;
        drain();

        // 5: back-to-back, 20 commands
        do_reset();
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            send(v_op[i % 8], v_a[i % 8], v_b[i % 8], v_exp[i % 8]);
            if (i > 0) check("t5_accept_gap", 32'(acc_cyc - prev), 32'd3);
            prev = acc_cyc;
        end
        drain();
        check("t5_cmd_count", 32'(cmd_count), 32'd20);
        check("t5_cmd_count_w4", 32'(cmd_count4), 32'd4);

        // 6: reset during DRIVE drops the command
        do_reset();
        send(3'b001, 8'h01, 8'h02, 16'h0003);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_cmd_count", 32'(cmd_count), 32'd0);
        check("t6_cmd_count_w4", 32'(cmd_count4), 32'd0);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t6_alu_reset", 32'(alu_reset), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
